// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Initiator side of a byte-addressed, big-endian 32-bit memory port. Takes
//   one load/store at a time and returns one response per request. Sub-word
//   stores are read-modify-write because the memory always writes 4 bytes.
//
//   state | meaning
//   IDLE  | ready for a request
//   RD    | memory word being read (load data or RMW merge source)
//   WR    | write strobe asserted for one cycle
//   RESP  | response held until resp_ready
//
// Ports
//   clk1, rst_n            clock, synchronous active-low reset
//   req_*                  request handshake and fields (registered on accept)
//   resp_*                 response handshake, load data, fault flag
//   mem_address/write/mask/w   memory drive; mem_read combinational read data
module mem_access_unit #(
  parameter int MEM_SIZE    = 1024,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic        clk1,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_store,
  input  logic        req_signed,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write,
  output logic [31:0] mem_mask,
  output logic        mem_w,
  input  logic [31:0] mem_read
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  // The memory always touches 4 bytes, so every access is bounded by the last word.
  localparam logic [31:0] LAST_ADDR = 32'(MEM_SIZE - 4);

  state_t      state, state_nx;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [23:0] data_q;
  logic [1:0]  size_q;
  logic        store_q, signed_q, err_q;
  logic        accept, fault, misaligned;
  logic [31:0] load_ext, store_data, size_mask;

  always_comb begin
    misaligned = 1'b0;
    if (ALIGN_CHECK) begin
      case (req_size)
        2'b01:   misaligned = req_addr[0];
        2'b10:   misaligned = |req_addr[1:0];
        default: misaligned = 1'b0;
      endcase
    end
    fault  = (req_addr > LAST_ADDR) || (req_size == 2'b11) || misaligned;
    accept = req_valid && (state == IDLE);
  end

  // Big-endian: the addressed byte sits in mem_read[31:24].
  always_comb begin
    case (size_q)
      2'b00:   load_ext = {{24{mem_read[31] & signed_q}}, mem_read[31:24]};
      2'b01:   load_ext = {{16{mem_read[31] & signed_q}}, mem_read[31:16]};
      default: load_ext = mem_read;
    endcase
  end

  always_comb begin
    case (size_q)
      2'b00: begin
        store_data = {wdata_q[7:0], data_q[23:0]};
        size_mask  = 32'hFF00_0000;
      end
      2'b01: begin
        store_data = {wdata_q[15:0], data_q[15:0]};
        size_mask  = 32'hFFFF_0000;
      end
      default: begin
        store_data = wdata_q;
        size_mask  = 32'hFFFF_FFFF;
      end
    endcase
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    mem_address = 32'h0;
    mem_write   = 32'h0;
    mem_mask    = 32'h0;
    mem_w       = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (accept) begin
          if (fault)                  state_nx = RESP;
          else if (!req_store)        state_nx = RD;
          else if (req_size == 2'b10) state_nx = WR;
          else                        state_nx = RD;
        end
      end
      RD: begin
        mem_address = addr_q;
        mem_mask    = size_mask;
        state_nx    = store_q ? WR : RESP;
      end
      WR: begin
        mem_address = addr_q;
        mem_mask    = size_mask;
        mem_write   = store_data;
        mem_w       = 1'b1;
        state_nx    = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      size_q   <= 2'b00;
      store_q  <= 1'b0;
      signed_q <= 1'b0;
      data_q   <= 24'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        size_q   <= req_size;
        store_q  <= req_store;
        signed_q <= req_signed;
        err_q    <= fault;
        rdata_q  <= 32'h0;
      end
      if (state == RD) begin
        data_q <= mem_read[23:0];
        if (!store_q) rdata_q <= load_ext;
      end
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk1, rst_n;
  logic        req_valid, req_valid_b, resp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        req_store, req_signed;

  logic        req_ready, resp_valid, resp_err, mem_w;
  logic [31:0] resp_rdata, mem_address, mem_write, mem_mask, mem_read;

  logic        req_ready_b, resp_valid_b, resp_err_b, mem_w_b;
  logic [31:0] resp_rdata_b, mem_address_b, mem_write_b, mem_mask_b, mem_read_b;

  logic [7:0]  mem [0:1023];

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  int          wcount = 0;
  logic [31:0] last_mask, last_wdata, last_waddr;
  logic        addr_nz = 1'b0;

  mem_access_unit #(.MEM_SIZE(1024), .ALIGN_CHECK(1'b1)) u_dut (
    .clk1(clk1), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size), .req_store(req_store),
    .req_signed(req_signed), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_address(mem_address),
    .mem_write(mem_write), .mem_mask(mem_mask), .mem_w(mem_w), .mem_read(mem_read)
  );

  mem_access_unit #(.MEM_SIZE(1024), .ALIGN_CHECK(1'b0)) u_dut_b (
    .clk1(clk1), .rst_n(rst_n),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size), .req_store(req_store),
    .req_signed(req_signed), .resp_valid(resp_valid_b), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata_b), .resp_err(resp_err_b), .mem_address(mem_address_b),
    .mem_write(mem_write_b), .mem_mask(mem_mask_b), .mem_w(mem_w_b), .mem_read(mem_read_b)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  // Big-endian byte memory: the addressed byte is bits [31:24].
  logic [9:0] ra, rb;
  always_comb begin
    ra = mem_address[9:0];
    rb = mem_address_b[9:0];
    mem_read   = {mem[ra], mem[ra + 10'd1], mem[ra + 10'd2], mem[ra + 10'd3]};
    mem_read_b = {mem[rb], mem[rb + 10'd1], mem[rb + 10'd2], mem[rb + 10'd3]};
  end

  always @(posedge clk1) begin
    logic [9:0] wa;
    wa = mem_address[9:0];
    if (mem_w) begin
      mem[wa]         <= mem_write[31:24];
      mem[wa + 10'd1] <= mem_write[23:16];
      mem[wa + 10'd2] <= mem_write[15:8];
      mem[wa + 10'd3] <= mem_write[7:0];
    end
  end

  always @(negedge clk1) begin
    if (mem_w) begin
      wcount     = wcount + 1;
      last_mask  = mem_mask;
      last_wdata = mem_write;
      last_waddr = mem_address;
    end
    if (mem_address != 32'h0) addr_nz = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      fails = fails + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request with resp_ready high; lat counts edges from accept to resp_valid.
  task automatic xfer(input logic b, input logic [31:0] a, input logic [31:0] wd,
                      input logic [1:0] sz, input logic st, input logic sg,
                      output logic [31:0] rd, output logic er, output int lat);
    int n;
    @(negedge clk1);
    req_addr = a; req_wdata = wd; req_size = sz; req_store = st; req_signed = sg;
    if (b) req_valid_b = 1'b1; else req_valid = 1'b1;
    n = 0;
    while (!(b ? req_ready_b : req_ready) && n < 20) begin
      @(negedge clk1);
      n++;
    end
    @(posedge clk1); #1;
    req_valid = 1'b0; req_valid_b = 1'b0;
    lat = 1;
    while (!(b ? resp_valid_b : resp_valid) && lat < 10) begin
      @(posedge clk1); #1;
      lat++;
    end
    rd = b ? resp_rdata_b : resp_rdata;
    er = b ? resp_err_b : resp_err;
    @(posedge clk1); #1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, wc0;
    logic        stable;

    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    rst_n = 1'b0; resp_ready = 1'b1;
    req_valid = 1'b0; req_valid_b = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; req_size = 2'b00; req_store = 1'b0; req_signed = 1'b0;
    repeat (2) @(posedge clk1);
    #1;
    chk("rst_flags", {28'h0, req_ready, resp_valid, resp_err, mem_w}, 32'h8);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_addr", mem_address, 32'h0);
    chk("rst_mask", mem_mask, 32'h0);
    chk("rst_wdata", mem_write, 32'h0);
    @(negedge clk1); rst_n = 1'b1;

    // word round trip
    wc0 = wcount;
    xfer(1'b0, 32'h10, 32'hDEADBEEF, 2'b10, 1'b1, 1'b0, rd, er, lat);
    chk("wst_lat", 32'(lat), 32'd2);
    chk("wst_err", {31'h0, er}, 32'h0);
    chk("wst_rdata", rd, 32'h0);
    chk("wst_wcount", 32'(wcount - wc0), 32'd1);
    chk("wst_waddr", last_waddr, 32'h10);
    chk("wst_mask", last_mask, 32'hFFFFFFFF);
    xfer(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 1'b0, rd, er, lat);
    chk("wld_data", rd, 32'hDEADBEEF);
    chk("wld_lat", 32'(lat), 32'd2);
    chk("wld_err", {31'h0, er}, 32'h0);

    // sub-word read-modify-write
    xfer(1'b0, 32'h20, 32'h11223344, 2'b10, 1'b1, 1'b0, rd, er, lat);
    xfer(1'b0, 32'h20, 32'hFFFFFFAB, 2'b00, 1'b1, 1'b0, rd, er, lat);
    chk("bst_lat", 32'(lat), 32'd3);
    chk("bst_mask", last_mask, 32'hFF000000);
    chk("bst_wdata", last_wdata, 32'hAB223344);
    xfer(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 1'b0, rd, er, lat);
    chk("bst_readback", rd, 32'hAB223344);
    xfer(1'b0, 32'h20, 32'h1234CDEF, 2'b01, 1'b1, 1'b0, rd, er, lat);
    chk("hst_lat", 32'(lat), 32'd3);
    chk("hst_mask", last_mask, 32'hFFFF0000);
    xfer(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 1'b0, rd, er, lat);
    chk("hst_readback", rd, 32'hCDEF3344);

    // sign / zero extension
    xfer(1'b0, 32'h40, 32'h80FF0000, 2'b10, 1'b1, 1'b0, rd, er, lat);
    xfer(1'b0, 32'h40, 32'h0, 2'b00, 1'b0, 1'b1, rd, er, lat);
    chk("lb_signed", rd, 32'hFFFFFF80);
    xfer(1'b0, 32'h40, 32'h0, 2'b00, 1'b0, 1'b0, rd, er, lat);
    chk("lb_unsigned", rd, 32'h00000080);
    xfer(1'b0, 32'h40, 32'h0, 2'b01, 1'b0, 1'b1, rd, er, lat);
    chk("lh_signed", rd, 32'hFFFF80FF);
    xfer(1'b0, 32'h40, 32'h0, 2'b01, 1'b0, 1'b0, rd, er, lat);
    chk("lh_unsigned", rd, 32'h000080FF);
    xfer(1'b0, 32'h40, 32'h0, 2'b10, 1'b0, 1'b1, rd, er, lat);
    chk("lw_signed_ignored", rd, 32'h80FF0000);

    // faults
    wc0 = wcount; addr_nz = 1'b0;
    xfer(1'b0, 32'h3FD, 32'h0, 2'b10, 1'b0, 1'b0, rd, er, lat);
    chk("oob_err", {31'h0, er}, 32'h1);
    chk("oob_lat", 32'(lat), 32'd1);
    xfer(1'b0, 32'h3FD, 32'h12345678, 2'b10, 1'b1, 1'b0, rd, er, lat);
    chk("oob_st_err", {31'h0, er}, 32'h1);
    xfer(1'b0, 32'h41, 32'h0, 2'b01, 1'b0, 1'b0, rd, er, lat);
    chk("mis_half_err", {31'h0, er}, 32'h1);
    xfer(1'b0, 32'h40, 32'h0, 2'b11, 1'b0, 1'b0, rd, er, lat);
    chk("size11_err", {31'h0, er}, 32'h1);
    chk("fault_no_write", 32'(wcount - wc0), 32'd0);
    chk("fault_addr_zero", {31'h0, addr_nz}, 32'h0);
    xfer(1'b0, 32'h3FC, 32'h0, 2'b10, 1'b0, 1'b0, rd, er, lat);
    chk("last_word_err", {31'h0, er}, 32'h0);
    chk("last_word_lat", 32'(lat), 32'd2);

    // alignment check disabled: half @0x41 reads bytes 41,42 = FF,00
    xfer(1'b1, 32'h41, 32'h0, 2'b01, 1'b0, 1'b0, rd, er, lat);
    chk("noalign_err", {31'h0, er}, 32'h0);
    chk("noalign_data", rd, 32'h0000FF00);

    // backpressure
    resp_ready = 1'b0;
    @(negedge clk1);
    req_addr = 32'h20; req_size = 2'b10; req_store = 1'b0; req_signed = 1'b0; req_valid = 1'b1;
    @(posedge clk1); #1;
    req_valid = 1'b0;
    @(posedge clk1); #1;
    req_addr = 32'h10; req_wdata = 32'h0; req_size = 2'b10; req_store = 1'b1; req_valid = 1'b1;
    wc0 = wcount; stable = 1'b1;
    repeat (5) begin
      if (!(resp_valid && resp_rdata == 32'hCDEF3344 && !resp_err && !req_ready)) stable = 1'b0;
      @(posedge clk1); #1;
    end
    chk("bp_stable", {31'h0, stable}, 32'h1);
    chk("bp_no_accept", 32'(wcount - wc0), 32'd0);
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk1); #1;
    chk("bp_release", {30'h0, req_ready, resp_valid}, 32'h2);
    xfer(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 1'b0, rd, er, lat);
    chk("bp_store_dropped", rd, 32'hDEADBEEF);

    // reset while in WR of a byte store; the bench memory commits that cycle's write
    @(negedge clk1);
    req_addr = 32'h40; req_wdata = 32'h55; req_size = 2'b00; req_store = 1'b1; req_valid = 1'b1;
    @(posedge clk1); #1;
    req_valid = 1'b0;
    chk("rmw_rd_mask", mem_mask, 32'hFF000000);
    @(posedge clk1); #1;
    chk("rmw_wr_strobe", {31'h0, mem_w}, 32'h1);
    chk("rmw_wr_data", mem_write, 32'h55FF0000);
    rst_n = 1'b0;
    @(posedge clk1); #1;
    chk("mid_rst_flags", {28'h0, req_ready, resp_valid, resp_err, mem_w}, 32'h8);
    chk("mid_rst_rdata", resp_rdata, 32'h0);
    chk("mid_rst_addr", mem_address, 32'h0);
    chk("mid_rst_mask", mem_mask, 32'h0);
    rst_n = 1'b1;
    @(posedge clk1); #1;
    chk("mid_rst_no_resp", {30'h0, req_ready, resp_valid}, 32'h2);
    xfer(1'b0, 32'h40, 32'h0, 2'b10, 1'b0, 1'b0, rd, er, lat);
    chk("post_rst_data", rd, 32'h55FF0000);
    chk("post_rst_lat", 32'(lat), 32'd2);
    xfer(1'b0, 32'h20, 32'h0, 2'b00, 1'b0, 1'b1, rd, er, lat);
    chk("post_rst_lb", rd, 32'hFFFFFFCD);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the byte-addressed, big-endian 32-bit memory port.
- Accepts one load/store request at a time from the pipeline and drives the memory's address, write data, mask and write strobe.
- Performs byte, halfword and word loads with sign/zero extension. Sub-word stores use read-modify-write because the memory writes all 4 bytes.
- Returns one response per request.

Parameters:
- MEM_SIZE, 1024, memory size in bytes; the last legal word address is MEM_SIZE-4.
- ALIGN_CHECK, 1, 1 = misaligned halfword/word access faults; 0 = issued as-is.

Ports:
- clk1  in  1  single clock, rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the operand is in the low bits.
- req_size  in  2  00 = byte, 01 = halfword, 10 = word; 11 is illegal.
- req_store  in  1  1 = store, 0 = load.
- req_signed  in  1  load sign-extends when 1.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes the response.
- resp_rdata  out  32  extended load data; 0 for stores.
- resp_err  out  1  fault: out of bounds, misaligned, or illegal size.
- mem_address  out  32  memory address.
- mem_write  out  32  memory write data.
- mem_mask  out  32  byte-lane mask of the bytes being modified.
- mem_w  out  1  memory write strobe.
- mem_read  in  32  memory read data; combinationally valid while mem_address is held.

Behaviour:
- FSM states: IDLE, RD, WR, RESP.
- Reset values: state = IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, mem_address = 0, mem_write = 0, mem_mask = 0, mem_w = 0.
- Handshake: req_ready = (state == IDLE). A request is accepted on an edge with req_valid & req_ready. All request fields are registered on accept.
- Transitions from IDLE on accept:
  - Fault → RESP with resp_err = 1. No memory access occurs.
  - Load → RD.
  - Word store → WR.
  - Byte/halfword store → RD.
- Transitions from RD: capture mem_read into a data register. Load → RESP. Sub-word store → WR.
- Transitions from WR: → RESP.
- Transitions from RESP: → IDLE on the edge where resp_ready = 1. resp_valid, resp_rdata and resp_err are held stable until then.
- Fault conditions:
  - req_addr > MEM_SIZE-4 (checked for all sizes, since the memory always touches 4 bytes).
  - req_size == 11.
  - When ALIGN_CHECK = 1: halfword with addr[0] ≠ 0, or word with addr[1:0] ≠ 0.
- Memory port:
  - mem_address = the registered address in RD and WR, 0 otherwise.
  - mem_w = (state == WR), decoded from state, so it is high for exactly one cycle per store.
  - mem_mask: byte = FF000000, half = FFFF0000, word = FFFFFFFF; 0 outside RD/WR.
- Big-endian lane mapping: the byte at the address is mem_read[31:24].
  - Byte load = data[31:24]; halfword load = data[31:16]; word load = data.
  - Extension: sign-extend when req_signed = 1, else zero-extend. req_signed is ignored for word.
- Store write data (mem_write in WR):
  - Word: wdata.
  - Half: {wdata[15:0], rd[15:0]}.
  - Byte: {wdata[7:0], rd[23:0]}.
  - rd is the word captured in RD.
- Latency, counted from the accept edge to resp_valid high:
  - Load: 2 cycles.
  - Word store: 2 cycles.
  - Sub-word store: 3 cycles.
  - Fault: 1 cycle.
- Back-to-back: with resp_ready held at 1, the next request is accepted on the cycle after the RESP handshake (IDLE reached), so there is 1 bubble cycle.
- Reset mid-operation: rst_n low on any edge forces the reset values. If reset occurs in RD, no write follows. If reset occurs in WR, mem_w drops after that edge; the in-flight write may already have been committed by the memory in that cycle. Any pending response is discarded.
- req_valid is ignored outside IDLE. Request inputs may change freely after accept.

Test Plan:
- Word round trip: store addr 0x10, data 0xDEADBEEF. Then load word from 0x10 → resp_rdata = DEADBEEF, err = 0. Check mem_w high exactly 1 cycle and latency = 2.
- Sub-word RMW: word store 0x11223344 @0x20. Then byte store 0xAB @0x20. Word load → AB223344. Halfword store 0xCDEF @0x20, then word load → CDEF3344. Check 3-cycle latency.
- Extension: word 0x80FF0000 @0x40. Signed byte load → FFFFFF80. Unsigned byte load → 00000080. Signed half → FFFF80FF.
- Faults: word load @0x3FD (MEM_SIZE = 1024) → err = 1, mem_w never high, mem_address stays 0. Half @0x41 → err. size = 11 → err. Repeat the half @0x41 case with ALIGN_CHECK = 0 → no err.
- Backpressure: hold resp_ready = 0 for 5 cycles → resp_valid and data stable, req_ready = 0, a new req_valid is not accepted. Release → handshake, IDLE next cycle.
- Reset in WR of a byte store: rst_n low → all outputs at reset values next cycle. A following load returns a consistent value and the unit resumes normally.
